// File: rtl/cam2gray_multi_pkg.sv
// cam_pkg: shared types and constants for the camera-to-gray front end.
//   fmt_e      - per-frame pixel format encoding
//   *_DEF      - default luma coefficients and shift
//   clip_max() - largest value representable in a given bit width
package cam_pkg;

  typedef enum logic [1:0] {
    FMT_RGB565 = 2'd0,
    FMT_YUV422 = 2'd1,
    FMT_RAW8   = 2'd2,
    FMT_RSVD   = 2'd3   // decoded exactly like RAW8
  } fmt_e;

  localparam int KR_DEF    = 4;
  localparam int KG_DEF    = 10;
  localparam int KB_DEF    = 2;
  localparam int SHIFT_DEF = 4;

  // Three 5-bit weights times 8-bit channels always fit in 15 bits.
  localparam int SUM_W = 15;

  function automatic int unsigned clip_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/cam2gray_multi_if.sv
// DVP byte bus from the image sensor.
//   master: sensor side (drives vsync/href/data)
//   slave : capture side (samples them)
interface cam2gray_multi_if;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_data;

  modport master (output cam_vsync, cam_href, cam_data);
  modport slave  (input  cam_vsync, cam_href, cam_data);
endinterface

// File: rtl/cam2gray_multi_calc.sv
// cam_gray_calc: two-stage weighted sum -> shift -> clip -> truncate.
//   r, g, b  : 8-bit channels (used when byp_sel=0)
//   byp      : ready-made 8-bit gray (used when byp_sel=1)
//   vld      : input qualifier
//   gray     : top OUT_W bits of the clipped 8-bit result
//   gray_vld : vld delayed by two cycles
// Bypassed values take the same two stages so every format has equal latency.
module cam_gray_calc
  import cam_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int KR    = KR_DEF,
  parameter int KG    = KG_DEF,
  parameter int KB    = KB_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       r,
  input  logic [7:0]       g,
  input  logic [7:0]       b,
  input  logic [7:0]       byp,
  input  logic             byp_sel,
  input  logic             vld,
  output logic [OUT_W-1:0] gray,
  output logic             gray_vld
);

  localparam int STAGES = 2;
  localparam logic [SUM_W-1:0] CLIP = SUM_W'(clip_max(8));

  logic [STAGES-1:0] vld_pipe;
  logic [SUM_W-1:0]  sum_c, s1_q, shr;
  logic              s1_byp;
  logic [7:0]        clip8;

  assign sum_c = SUM_W'(KR) * SUM_W'(r)
               + SUM_W'(KG) * SUM_W'(g)
               + SUM_W'(KB) * SUM_W'(b);

  assign shr   = s1_q >> SHIFT;
  assign clip8 = s1_byp      ? s1_q[7:0] :
                 (shr > CLIP) ? 8'hFF    : shr[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s1_byp   <= 1'b0;
      gray     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], vld};
      s1_q     <= byp_sel ? SUM_W'(byp) : sum_c;
      s1_byp   <= byp_sel;
      gray     <= clip8[7 -: OUT_W];
    end
  end

  assign gray_vld = vld_pipe[STAGES-1];

endmodule

// File: rtl/cam2gray_multi.sv
// cam2gray_multi: DVP capture, per-frame format decode (RGB565/YUV422/RAW8)
// and gray conversion with line/frame markers.
//   clk, rst            : pixel clock, synchronous active-high reset
//   cam                 : DVP bus (vsync, href, 8-bit data)
//   fmt                 : format, latched on every vsync rise
//   cmos_h, cmos_v      : expected pixels per line / lines per frame
//   gray_en, gray_data  : gray pixel stream
//   pic_start           : pulse on vsync rise
//   href_start/href_end : pulses at line start / after the line's last pixel
//   first/second/last_href : level flags on line_cnt
//   line_cnt, pix_cnt   : 1-based line number, pixels emitted in the line
//   line_err            : pulse with href_end when pix_cnt != cmos_h
// The block ignores everything until the first vsync rise after reset, so a
// partial frame never reaches the line buffer.
module cam2gray_multi
  import cam_pkg::*;
#(
  parameter int OUT_W       = 8,
  parameter int KR          = KR_DEF,
  parameter int KG          = KG_DEF,
  parameter int KB          = KB_DEF,
  parameter int SHIFT       = SHIFT_DEF,
  parameter int LINE_W      = 11,
  parameter int PIX_W       = 12,
  parameter int SYNC_STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  cam2gray_multi_if.slave   cam,
  input  logic [1:0]        fmt,
  input  logic [PIX_W-1:0]  cmos_h,
  input  logic [15:0]       cmos_v,
  output logic              gray_en,
  output logic [OUT_W-1:0]  gray_data,
  output logic              pic_start,
  output logic              href_start,
  output logic              href_end,
  output logic              first_href,
  output logic              second_href,
  output logic              last_href,
  output logic [LINE_W-1:0] line_cnt,
  output logic [PIX_W-1:0]  pix_cnt,
  output logic              line_err
);

  localparam int S = SYNC_STAGES;

  // ---- input synchroniser ----
  logic [S-1:0]      vs_sr, hr_sr;
  logic [S-1:0][7:0] d_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_sr <= '0;
      hr_sr <= '0;
      d_sr  <= '0;
    end else begin
      vs_sr <= {vs_sr[S-2:0], cam.cam_vsync};
      hr_sr <= {hr_sr[S-2:0], cam.cam_href};
      d_sr  <= {d_sr[S-2:0],  cam.cam_data};
    end
  end

  // Edges come from stage S-1 vs stage S, so a line-start event fires one
  // cycle before the first byte of that line sits at stage S.
  logic       vs_rise, hr_rise, hr_fall, hr_s;
  logic [7:0] byte_s;
  assign vs_rise = vs_sr[S-2] & ~vs_sr[S-1];
  assign hr_rise = hr_sr[S-2] & ~hr_sr[S-1];
  assign hr_fall = ~hr_sr[S-2] & hr_sr[S-1];
  assign hr_s    = hr_sr[S-1];
  assign byte_s  = d_sr[S-1];

  // ---- control state ----
  logic       armed, in_line, phase;
  logic [7:0] hi_q;
  fmt_e       fmt_q;
  logic [1:0] end_pipe;

  // A vsync rise arms the block in the same cycle, so a coincident href
  // rise already counts as the first line of the new frame.
  logic line_go, byte_vld, two_byte, pix_vld;
  assign line_go  = hr_rise & (armed | vs_rise);
  assign byte_vld = in_line & hr_s;
  assign two_byte = (fmt_q == FMT_RGB565) || (fmt_q == FMT_YUV422);
  assign pix_vld  = byte_vld & (~two_byte | phase);

  // ---- decode: hi_q holds the first byte of a pair ----
  logic [7:0] r_c, g_c, b_c, byp_c;
  logic       byp_sel;
  assign r_c     = {hi_q[7:3], 3'b000};
  assign g_c     = {hi_q[2:0], byte_s[7:5], 2'b00};
  assign b_c     = {byte_s[4:0], 3'b000};
  assign byp_c   = (fmt_q == FMT_YUV422) ? hi_q : byte_s;
  assign byp_sel = (fmt_q != FMT_RGB565);

  cam_gray_calc #(
    .OUT_W(OUT_W), .KR(KR), .KG(KG), .KB(KB), .SHIFT(SHIFT)
  ) u_calc (
    .clk      (clk),
    .rst      (rst),
    .r        (r_c),
    .g        (g_c),
    .b        (b_c),
    .byp      (byp_c),
    .byp_sel  (byp_sel),
    .vld      (pix_vld),
    .gray     (gray_data),
    .gray_vld (gray_en)
  );

  // Count including the pixel on gray_en this cycle, so line_err sees the
  // final total in the same cycle href_end is registered.
  logic [PIX_W-1:0] pix_nxt;
  assign pix_nxt = (gray_en && (pix_cnt != '1)) ? pix_cnt + PIX_W'(1) : pix_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed       <= 1'b0;
      in_line     <= 1'b0;
      phase       <= 1'b0;
      hi_q        <= '0;
      fmt_q       <= FMT_RGB565;
      end_pipe    <= '0;
      line_cnt    <= '0;
      pix_cnt     <= '0;
      pic_start   <= 1'b0;
      href_start  <= 1'b0;
      href_end    <= 1'b0;
      line_err    <= 1'b0;
      first_href  <= 1'b0;
      second_href <= 1'b0;
      last_href   <= 1'b0;
    end else begin
      pic_start  <= vs_rise;
      href_start <= line_go;

      if (vs_rise) begin
        armed <= 1'b1;
        fmt_q <= fmt_e'(fmt);
      end

      if (vs_rise && line_go)
        line_cnt <= LINE_W'(1);
      else if (vs_rise)
        line_cnt <= '0;
      else if (line_go && (line_cnt != '1))
        line_cnt <= line_cnt + LINE_W'(1);

      if (line_go)      in_line <= 1'b1;
      else if (hr_fall) in_line <= 1'b0;

      if (line_go)
        phase <= 1'b0;
      else if (byte_vld && two_byte)
        phase <= ~phase;

      if (byte_vld && !phase)
        hi_q <= byte_s;

      pix_cnt <= line_go ? '0 : pix_nxt;

      // Last byte leaves stage S on hr_fall; its pixel reaches gray_en two
      // cycles later, and the end marker follows one cycle after that.
      end_pipe <= {end_pipe[0], hr_fall & in_line};
      href_end <= end_pipe[1];
      line_err <= end_pipe[1] && (pix_nxt != cmos_h);

      first_href  <= (line_cnt == LINE_W'(1));
      second_href <= (line_cnt == LINE_W'(2));
      last_href   <= (32'(line_cnt) == 32'(cmos_v));
    end
  end

endmodule
